// File: rtl/uart_pkg.sv
// Shared definitions for the MVM UART transmitter (and its rx counterpart):
// default timing/framing constants, the frame FSM state type and the
// parity helper.
package uart_pkg;

  localparam int CLOCKS_PER_PULSE = 2604;  // 50 MHz / 19200 baud
  localparam int BITS_PER_WORD    = 8;
  localparam int PACKET_SIZE_TX   = 13;    // start + data + trailing ones

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Even parity bit for a word: XOR of all its bits. Narrower words are
  // zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLOCKS_PER_PULSE-1 while enabled and
// emits a one-cycle tick on the terminal count. Clear has priority over
// enable. Shared by the tx and rx sides.
module uart_baud_cnt #(
  parameter int CLOCKS_PER_PULSE = uart_pkg::CLOCKS_PER_PULSE
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  assign w_tick = i_en && (r_cnt == CNT_LAST);
  assign o_tick = w_tick;

  // Pulse counter: wraps at terminal count, never exceeds it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tick ? '0 : (r_cnt + CNT_ONE);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parallel-to-serial UART transmitter. Accepts one N_WORDS-word bus per
// valid/ready handshake and sends it word 0 first; each word is a packet of
// start bit, data bits LSB first, then trailing ones up to PACKET_SIZE bits.
// tx is registered: the start bit appears the cycle after the handshake.
// Optional build macro UART_TX_PARITY_EN: the bit after the data carries
// even parity of the word instead of a padding one.
module uart_tx_frame #(
  parameter int CLOCKS_PER_PULSE = uart_pkg::CLOCKS_PER_PULSE,
  parameter int BITS_PER_WORD    = uart_pkg::BITS_PER_WORD,
  parameter int PACKET_SIZE      = uart_pkg::PACKET_SIZE_TX,
  parameter int N_WORDS          = 2
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [N_WORDS*BITS_PER_WORD-1:0]   s_data,
  output logic                               tx,
  output logic                               busy
);

  import uart_pkg::*;

  localparam int W_BUS = N_WORDS * BITS_PER_WORD;
  localparam int BW    = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
  localparam int WW    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(PACKET_SIZE - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [WW-1:0] WORD_LAST = WW'(N_WORDS - 1);
  localparam logic [WW-1:0] WORD_ONE  = WW'(1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [W_BUS-1:0]         r_shift;
  logic [BW-1:0]            r_bit_cnt;
  logic [BW-1:0]            w_bit_nxt;
  logic [WW-1:0]            r_word_cnt;
  logic [WW-1:0]            w_word_nxt;
  logic                     r_tx;
  logic                     w_tx_nxt;
  logic                     w_tick;
  logic                     w_frame_end;
  logic                     w_handshake;
  logic                     w_baud_en;
  logic                     w_baud_clr;
  logic [BITS_PER_WORD-1:0] w_cur_word;

  assign w_handshake = (r_state == IDLE) && s_valid;
  assign w_baud_en   = (r_state == SEND);
  assign w_baud_clr  = (r_state == IDLE);
  assign w_frame_end = w_tick && (r_bit_cnt == BIT_LAST) && (r_word_cnt == WORD_LAST);

  uart_baud_cnt #(
    .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE)
  ) u_baud (
    .clk    (clk),
    .rstn   (rstn),
    .i_en   (w_baud_en),
    .i_clr  (w_baud_clr),
    .o_tick (w_tick)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: start on handshake, stop after the final bit period.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (s_valid)     w_state_nxt = SEND;
      SEND:    if (w_frame_end) w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // Next bit/word position: bit advances on each baud tick, word on bit wrap.
  always_comb begin
    w_bit_nxt  = r_bit_cnt;
    w_word_nxt = r_word_cnt;
    if (w_tick) begin
      if (r_bit_cnt == BIT_LAST) begin
        w_bit_nxt  = '0;
        w_word_nxt = (r_word_cnt == WORD_LAST) ? '0 : (r_word_cnt + WORD_ONE);
      end else begin
        w_bit_nxt  = r_bit_cnt + BIT_ONE;
      end
    end
  end

  // Position counters and bus capture; the bus is latched only on handshake
  // so later changes on s_data cannot disturb the frame in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_shift    <= '0;
    end else begin
      r_bit_cnt  <= w_bit_nxt;
      r_word_cnt <= w_word_nxt;
      if (w_handshake) begin
        r_shift <= s_data;
      end
    end
  end

  // Select the word that will be on the line next cycle.
  always_comb begin
    w_cur_word = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      if (w_word_nxt == WW'(i)) begin
        w_cur_word = r_shift[i*BITS_PER_WORD +: BITS_PER_WORD];
      end
    end
  end

  // FSM outputs: handshake flags and the next line level. The line value is
  // derived from next-cycle position so the registered tx lines up with it;
  // on the handshake cycle the next position is the start bit, which needs
  // no data, so the not-yet-latched bus is never read.
  always_comb begin
    s_ready  = (r_state == IDLE);
    busy     = (r_state == SEND);
    w_tx_nxt = 1'b1;
    if (w_state_nxt == SEND) begin
      if (w_bit_nxt == '0) begin
        w_tx_nxt = 1'b0;
      end
      for (int k = 0; k < BITS_PER_WORD; k++) begin
        if (w_bit_nxt == BW'(k + 1)) begin
          w_tx_nxt = w_cur_word[k];
        end
      end
`ifdef UART_TX_PARITY_EN
      if (w_bit_nxt == BW'(BITS_PER_WORD + 1)) begin
        w_tx_nxt = even_parity(32'(w_cur_word));
      end
`endif
    end
  end

  // Line register: idles high and is forced high immediately on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx <= 1'b1;
    end else begin
      r_tx <= w_tx_nxt;
    end
  end

  assign tx = r_tx;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame with 4 clocks per bit, 2 words, 13-bit packets.
module tb_uart_tx_frame;

  localparam int CPP       = 4;
  localparam int BPW       = 8;
  localparam int PS        = 13;
  localparam int NW        = 2;
  localparam int FRAME_CYC = NW * PS * CPP;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        tx;
  logic        busy;

  int   n_cmp;
  int   n_fail;
  logic trace [FRAME_CYC];

  uart_tx_frame #(
    .CLOCKS_PER_PULSE (CPP),
    .BITS_PER_WORD    (BPW),
    .PACKET_SIZE      (PS),
    .N_WORDS          (NW)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .tx      (tx),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference line level for cycle cyc of a frame carrying bus.
  function automatic logic model_tx(input logic [15:0] bus, input int cyc);
    int         p;
    int         w;
    int         b;
    logic [7:0] word;
    p    = cyc / CPP;
    w    = p / PS;
    b    = p % PS;
    word = 8'(bus >> (w * BPW));
    if (b == 0)                return 1'b0;
    if (b <= BPW)              return word[b-1];
    if (b == BPW + 1 && PAR_EN) return ^word;
    return 1'b1;
  endfunction

  // Mid-bit sampling decoder over a recorded frame.
  function automatic logic [15:0] decode();
    logic [15:0] bus;
    bus = '0;
    for (int w = 0; w < NW; w++)
      for (int i = 0; i < BPW; i++)
        bus[w*BPW + i] = trace[(w*PS + 1 + i)*CPP + CPP/2];
    return bus;
  endfunction

  function automatic logic bit_at(input int w, input int b);
    return trace[(w*PS + b)*CPP + CPP/2];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer bus d, then follow the whole frame cycle by cycle.
  task automatic frame(input logic [15:0] d, input bit hold, input bit mutate, input string tag);
    int wave_err;
    int busy_err;
    wave_err = 0;
    busy_err = 0;
    s_data  = d;
    s_valid = 1'b1;
    tick();
    if (mutate) s_data = 16'h1234;
    if (!hold) s_valid = 1'b0;
    for (int k = 0; k < FRAME_CYC; k++) begin
      trace[k] = tx;
      if (tx !== model_tx(d, k)) wave_err++;
      if (busy !== 1'b1 || s_ready !== 1'b0) busy_err++;
      tick();
    end
    check({tag, "_wave_errs"}, wave_err, 0);
    check({tag, "_busy_errs"}, busy_err, 0);
    check({tag, "_ready_end"}, {31'd0, s_ready}, 1);
    check({tag, "_busy_end"}, {31'd0, busy}, 0);
    check({tag, "_tx_end"}, {31'd0, tx}, 1);
    check({tag, "_decoded"}, {16'd0, decode()}, {16'd0, d});
  endtask

  initial begin
    int          idle_err;
    logic [15:0] rd;
    bit          rh;
    n_cmp   = 0;
    n_fail  = 0;
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_data  = 16'h0000;

    // Reset state
    repeat (3) tick();
    check("rst_tx", {31'd0, tx}, 1);
    check("rst_ready", {31'd0, s_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    rstn = 1'b1;
    idle_err = 0;
    repeat (20) begin
      tick();
      if (tx !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0) idle_err++;
    end
    check("post_rst_idle_errs", idle_err, 0);

    // Single frame
    frame(16'hA53C, 1'b0, 1'b0, "single");
    check("single_w0_b3", {31'd0, bit_at(0, 3)}, 1);
    check("single_w1_b1", {31'd0, bit_at(1, 1)}, 1);
    tick();
    tick();

    // Back-to-back frames with s_valid held high
    frame(16'h00FF, 1'b1, 1'b0, "b2b_a");
    frame(16'hFFFF, 1'b1, 1'b0, "b2b_b");
    s_valid = 1'b0;
    tick();

    // Data mutation after handshake
    frame(16'hA53C, 1'b0, 1'b1, "mutate");
    tick();

    // Parity / padding bit after the data
    frame(16'h0701, 1'b0, 1'b0, "par_0701");
    check("par_0701_w0_b9", {31'd0, bit_at(0, 9)}, 1);
    check("par_0701_w1_b9", {31'd0, bit_at(1, 9)}, 1);
    frame(16'h0303, 1'b0, 1'b0, "par_0303");
    check("par_0303_w0_b9", {31'd0, bit_at(0, 9)}, {31'd0, !PAR_EN});
    check("par_0303_w1_b9", {31'd0, bit_at(1, 9)}, {31'd0, !PAR_EN});
    check("par_0303_w0_b10", {31'd0, bit_at(0, 10)}, 1);

    // Mid-frame reset during word 0 bit 5 (data zero, so line is low)
    s_data  = 16'h0000;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    repeat (21) tick();
    check("mid_pre_rst_tx", {31'd0, tx}, 0);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_tx_async", {31'd0, tx}, 1);
    check("mid_rst_ready", {31'd0, s_ready}, 1);
    check("mid_rst_busy", {31'd0, busy}, 0);
    tick();
    tick();
    rstn = 1'b1;
    idle_err = 0;
    repeat (12) begin
      tick();
      if (tx !== 1'b1 || s_ready !== 1'b1) idle_err++;
    end
    check("mid_post_rel_idle_errs", idle_err, 0);
    frame(16'h0001, 1'b0, 1'b0, "after_rst");
    tick();

    // Randomized frames, mixing single-cycle and held s_valid
    for (int n = 0; n < 8; n++) begin
      rd = 16'($urandom);
      rh = 1'($urandom_range(0, 1));
      frame(rd, rh, 1'b0, "rand");
      if (!rh) tick();
    end
    s_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
